// File: rtl/spi_slave_port.sv
// SPI mode-0 responder. The external SCLK/CS_N/MOSI pins are oversampled on clk,
// words are shifted MSB-first in both directions, and whole words are exchanged
// with fabric through a single-entry tx buffer and an rx valid pulse.
module spi_slave_port #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);

  localparam int unsigned CntW   = $clog2(WIDTH + 1);
  localparam int unsigned FlushW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_hist, cs_hist;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_e             state;
  logic [FlushW-1:0]  flush_cnt;
  logic [CntW-1:0]    bit_cnt;
  logic [WIDTH-2:0]   tx_sh;   // bits still to be presented after the one on miso
  logic [WIDTH-2:0]   rx_sh;   // bits received so far in the current word
  logic [WIDTH-1:0]   tx_buf;

  logic [WIDTH-1:0]   rx_word;
  logic [WIDTH-1:0]   tx_next_word;
  logic [CntW-1:0]    cnt_rise;
  logic [CntW-1:0]    cnt_eff;
  logic               load_ok;
  logic               consume;

  // Synchronisers plus one history flop per pin; reset to the idle bus levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  // Edge strobes and next-value helpers for the protocol FSM.
  always_comb begin
    sclk_s       = sclk_sync[SYNC_STAGES-1];
    cs_s         = cs_sync[SYNC_STAGES-1];
    mosi_s       = mosi_sync[SYNC_STAGES-1];
    sclk_rise    = sclk_s & ~sclk_hist;
    sclk_fall    = ~sclk_s & sclk_hist;
    cs_rise      = cs_s & ~cs_hist;
    cs_fall      = ~cs_s & cs_hist;
    rx_word      = {rx_sh, mosi_s};
    // An empty buffer hands out zeros.
    tx_next_word = tx_ready ? '0 : tx_buf;
    cnt_rise     = (bit_cnt == CntW'(WIDTH)) ? CntW'(1) : bit_cnt + CntW'(1);
    // Count as it stands once a coincident sclk rise has been applied.
    cnt_eff      = sclk_rise ? cnt_rise : bit_cnt;
    load_ok      = tx_load & tx_ready;
    consume      = ((state == StIdle) && cs_fall) ||
                   ((state == StShift) && sclk_fall && (bit_cnt == CntW'(WIDTH)));
  end

  // Protocol FSM, tx buffer handshake and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StWaitIdle;
      flush_cnt   <= '0;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // A load in the consume cycle refills the buffer the consume just emptied.
      if (load_ok) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (consume) begin
        tx_ready <= 1'b1;
      end

      case (state)
        StWaitIdle: begin
          spi_miso_oe <= 1'b0;
          // Let the synchronisers flush the reset levels before trusting cs_n high.
          if (flush_cnt != FlushW'(SYNC_STAGES + 1)) begin
            flush_cnt <= flush_cnt + FlushW'(1);
          end else if (cs_s && cs_hist) begin
            state <= StIdle;
          end
        end

        StIdle: begin
          spi_miso_oe <= 1'b0;
          if (cs_fall) begin
            tx_sh       <= tx_next_word[WIDTH-2:0];
            spi_miso    <= tx_next_word[WIDTH-1];
            spi_miso_oe <= 1'b1;
            bit_cnt     <= '0;
            state       <= StShift;
          end
        end

        StShift: begin
          if (sclk_rise) begin
            rx_sh   <= rx_word[WIDTH-2:0];
            bit_cnt <= cnt_rise;
            if (cnt_rise == CntW'(WIDTH)) begin
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
            end
          end
          if (sclk_fall) begin
            if (bit_cnt == CntW'(WIDTH)) begin
              tx_sh    <= tx_next_word[WIDTH-2:0];
              spi_miso <= tx_next_word[WIDTH-1];
              bit_cnt  <= '0;
            end else begin
              tx_sh    <= tx_sh << 1;
              spi_miso <= tx_sh[WIDTH-2];
            end
          end
          if (cs_rise) begin
            if ((cnt_eff != '0) && (cnt_eff != CntW'(WIDTH))) begin
              frame_err <= 1'b1;
            end
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt     <= '0;
            state       <= StIdle;
          end
        end

        default: state <= StWaitIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: acts as SPI master and fabric, keeps a word-level model
// of the tx buffer and the expected rx words, and checks the DUT against it.
module tb_spi_slave_port;

  logic       clk;
  logic       reset;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  spi_slave_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  logic       m_full;
  logic [7:0] m_buf;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rx_data;
  int         exp_err;
  int         seen_err;

  // Per-frame stimulus
  logic [7:0] mw     [4];
  logic       ld_en  [4];
  logic [7:0] ld_val [4];
  logic [7:0] cap    [4];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Every cycle: rx_data must hold its last word unless a pulse delivers the next one.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          check("rx_valid_unexpected", 32'(rx_valid), 32'(0));
        end else begin
          exp_rx_data = exp_rx.pop_front();
          check("rx_data", 32'(rx_data), 32'(exp_rx_data));
        end
      end else begin
        check("rx_hold", 32'(rx_data), 32'(exp_rx_data));
      end
      if (frame_err) seen_err++;
    end
  end

  task automatic model_consume(output logic [7:0] w);
    w = m_full ? m_buf : 8'h00;
    m_full = 1'b0;
  endtask

  task automatic fab_load3(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int n);
    logic [7:0] d [3];
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    @(posedge clk);
    #1;
    check("tx_ready_pre_load", 32'(tx_ready), 32'(!m_full));
    for (int i = 0; i < n; i++) begin
      tx_data = d[i];
      tx_load = 1'b1;
      if (!m_full) begin
        m_full = 1'b1;
        m_buf  = d[i];
      end
      @(posedge clk);
      #1;
    end
    tx_load = 1'b0;
  endtask

  task automatic fab_load(input logic [7:0] d);
    fab_load3(d, 8'h00, 8'h00, 1);
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      ld_en[i] = 1'b0;
      cap[i]   = 8'h00;
    end
  endtask

  // One CS-low frame of nwords words; the last word is cut after last_bits bits.
  task automatic spi_frame(input int nwords, input int last_bits);
    logic [7:0] cur;
    int nb;
    spi_cs_n = 1'b0;
    model_consume(cur);
    #60;
    for (int w = 0; w < nwords; w++) begin
      nb = (w == nwords - 1) ? last_bits : 8;
      for (int b = 0; b < nb; b++) begin
        spi_mosi = mw[w][7-b];
        if (b == 1 && ld_en[w]) fab_load(ld_val[w]);
        #50;
        check("miso_bit", 32'(spi_miso), 32'(cur[7-b]));
        check("miso_oe_active", 32'(spi_miso_oe), 32'(1));
        check("tx_ready", 32'(tx_ready), 32'(!m_full));
        cap[w][7-b] = spi_miso;
        spi_sclk = 1'b1;
        if (b == 7) exp_rx.push_back(mw[w]);
        #50;
        spi_sclk = 1'b0;
        if (b == 7) model_consume(cur);
      end
    end
    if (last_bits != 8) exp_err++;
    #50;
    spi_cs_n = 1'b1;
    #120;
    check("miso_oe_idle", 32'(spi_miso_oe), 32'(0));
    check("frame_err_count", 32'(seen_err), 32'(exp_err));
    check("rx_pending", 32'(exp_rx.size()), 32'(0));
  endtask

  task automatic check_reset_vals();
    check("rst_miso", 32'(spi_miso), 32'(0));
    check("rst_miso_oe", 32'(spi_miso_oe), 32'(0));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
  endtask

  initial begin
    int nw;
    int lb;
    reset       = 1'b1;
    spi_sclk    = 1'b0;
    spi_cs_n    = 1'b1;
    spi_mosi    = 1'b0;
    tx_data     = 8'h00;
    tx_load     = 1'b0;
    m_full      = 1'b0;
    m_buf       = 8'h00;
    exp_rx_data = 8'h00;
    exp_err     = 0;
    seen_err    = 0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    repeat (10) @(posedge clk);

    // 1: single word
    fab_load(8'hA5);
    mw[0] = 8'h3C;
    spi_frame(1, 8);
    check("t1_miso_word", 32'(cap[0]), 32'h A5);
    check("t1_rx_data", 32'(rx_data), 32'h 3C);
    check("t1_tx_ready", 32'(tx_ready), 32'(1));

    // 2: back-to-back words, second loaded after the first consume
    clr();
    fab_load(8'h81);
    mw[0] = 8'h12;
    mw[1] = 8'h34;
    ld_en[0]  = 1'b1;
    ld_val[0] = 8'h7E;
    spi_frame(2, 8);
    check("t2_miso_word0", 32'(cap[0]), 32'h 81);
    check("t2_miso_word1", 32'(cap[1]), 32'h 7E);
    check("t2_rx_data", 32'(rx_data), 32'h 34);

    // 3: empty buffer
    clr();
    mw[0] = 8'h9A;
    spi_frame(1, 8);
    check("t3_miso_word", 32'(cap[0]), 32'h 00);
    check("t3_tx_ready", 32'(tx_ready), 32'(1));
    check("t3_rx_data", 32'(rx_data), 32'h 9A);

    // 4: aborted after 5 bits, then a clean frame
    clr();
    mw[0] = 8'hC3;
    spi_frame(1, 5);
    check("t4_rx_unchanged", 32'(rx_data), 32'h 9A);
    check("t4_err_seen", 32'(seen_err), 32'(1));
    mw[0] = 8'hF0;
    spi_frame(1, 8);
    check("t4_rx_data", 32'(rx_data), 32'h F0);

    // 5: reset at bit 3 with CS low
    clr();
    fab_load(8'hE7);
    spi_cs_n = 1'b0;
    #60;
    for (int b = 0; b < 3; b++) begin
      spi_mosi = b[0];
      #50 spi_sclk = 1'b1;
      #50 spi_sclk = 1'b0;
    end
    @(posedge clk);
    #1;
    reset       = 1'b1;
    m_full      = 1'b0;
    exp_rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    for (int b = 0; b < 5; b++) begin
      spi_mosi = 1'b1;
      #50 spi_sclk = 1'b1;
      #50 spi_sclk = 1'b0;
      check("t5_oe_ignored", 32'(spi_miso_oe), 32'(0));
    end
    #50 spi_cs_n = 1'b1;
    #120;
    check("t5_err_none", 32'(seen_err), 32'(exp_err));
    mw[0] = 8'h55;
    spi_frame(1, 8);
    check("t5_rx_data", 32'(rx_data), 32'h 55);

    // 6: load held three cycles
    clr();
    fab_load3(8'h11, 8'h22, 8'h33, 3);
    mw[0] = 8'h0F;
    spi_frame(1, 8);
    check("t6_miso_word", 32'(cap[0]), 32'h 11);

    // Randomised frames against the model
    for (int f = 0; f < 40; f++) begin
      clr();
      nw = int'($urandom_range(1, 3));
      lb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      for (int w = 0; w < 4; w++) begin
        mw[w]     = 8'($urandom);
        ld_en[w]  = $urandom_range(0, 1) == 1;
        ld_val[w] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) fab_load(8'($urandom));
      spi_frame(nw, lb);
    end

    check("final_err_count", 32'(seen_err), 32'(exp_err));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
